// File: rtl/interrupt_arbiter_pkg.sv
// Shared definitions for the 65ce02 interrupt arbiter.
// Holds the FSM state encoding, the fixed vector low bytes and the
// grant/priority codes used by the arbiter and its priority encoder.
package interrupt_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE          = 2'd0,
    ST_SERVICE       = 2'd1,
    ST_HYPER_SERVICE = 2'd2
  } arb_state_t;

  // Kind of sequence granted, listed from highest to lowest priority.
  typedef enum logic [2:0] {
    PRIO_NONE  = 3'd0,
    PRIO_RESET = 3'd1,
    PRIO_HYP   = 3'd2,
    PRIO_NMI   = 3'd3,
    PRIO_IRQ   = 3'd4
  } prio_t;

  localparam logic [7:0] VEC_LO_RESET = 8'hFC;
  localparam logic [7:0] VEC_LO_NMI   = 8'hFA;
  localparam logic [7:0] VEC_LO_HYP   = 8'hF8;

endpackage

// File: rtl/interrupt_arbiter_irq_prio_enc.sv
// Masked priority encoder for the maskable IRQ channels.
// Ports:
//   i_req   - per-channel request, already qualified by mask/enables
//   o_valid - at least one request is present
//   o_idx   - index of the lowest-numbered (highest priority) request
module irq_prio_enc #(
  parameter int unsigned NUM_IRQ = 8
) (
  input  logic [NUM_IRQ-1:0] i_req,
  output logic               o_valid,
  output logic [2:0]         o_idx
);

  always_comb begin
    o_valid = 1'b0;
    o_idx   = '0;
    for (int unsigned k = 0; k < NUM_IRQ; k++) begin
      if (i_req[k] && !o_valid) begin
        o_valid = 1'b1;
        o_idx   = 3'(k);
      end
    end
  end

endmodule

// File: rtl/interrupt_arbiter.sv
// Interrupt / trap arbiter for the 65ce02 core.
// Arbitrates reset, hypervisor trap, NMI and maskable IRQs at instruction
// boundaries and presents the vector address of the granted sequence.
// Ports:
//   clk, reset            - clock, synchronous active-high reset
//   ready                 - clock enable (NMI edge latch ignores it)
//   irq, nmi, hyp         - interrupt sources
//   mc_sync, i_flag       - instruction boundary, P.I flag
//   hyper_rti             - hypervisor return pulse
//   mask_we, mask_wdata   - IRQ enable mask write port
//   intg, nmig, hyperg, resp, irq_id - active sequence and its type
//   pc_hold, hyper_mode   - PC increment suppress, hypervisor mode
//   vector_hi, vector_lo  - vector fetch address
module interrupt_arbiter
  import interrupt_arbiter_pkg::*;
#(
  parameter int unsigned NUM_IRQ      = 8,
  parameter logic [7:0]  VEC_PAGE     = 8'hFF,
  parameter logic [7:0]  IRQ_VEC_BASE = 8'hE0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               ready,
  input  logic [NUM_IRQ-1:0] irq,
  input  logic               nmi,
  input  logic               hyp,
  input  logic               mc_sync,
  input  logic               i_flag,
  input  logic               hyper_rti,
  input  logic               mask_we,
  input  logic [NUM_IRQ-1:0] mask_wdata,
  output logic               intg,
  output logic               nmig,
  output logic               hyperg,
  output logic               resp,
  output logic [2:0]         irq_id,
  output logic               pc_hold,
  output logic               hyper_mode,
  output logic [7:0]         vector_hi,
  output logic [7:0]         vector_lo
);

  arb_state_t         r_state, w_next_state;
  prio_t              r_grant, w_next_grant;
  logic [2:0]         r_irq_id, w_next_irq_id;
  logic               r_rst_pend;
  logic               r_nmi_prev;
  logic               r_nmi_latch;
  logic               r_hyper_mode;
  logic [NUM_IRQ-1:0] r_mask;

  logic [NUM_IRQ-1:0] w_irq_elig;
  logic               w_irq_valid;
  logic [2:0]         w_irq_idx;
  logic               w_nmi_edge;
  logic               w_take_rst;
  logic               w_take_nmi;
  logic               w_hyper_exit;

  assign w_irq_elig = irq & r_mask & {NUM_IRQ{~i_flag & ~r_hyper_mode}};
  assign w_nmi_edge = nmi & ~r_nmi_prev;

  irq_prio_enc #(
    .NUM_IRQ(NUM_IRQ)
  ) u_prio_enc (
    .i_req  (w_irq_elig),
    .o_valid(w_irq_valid),
    .o_idx  (w_irq_idx)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else if (ready) begin
      r_state <= w_next_state;
    end
  end

  // Next state and grant; only takes effect on ready edges.
  always_comb begin
    w_next_state  = r_state;
    w_next_grant  = r_grant;
    w_next_irq_id = r_irq_id;
    w_take_rst    = 1'b0;
    w_take_nmi    = 1'b0;
    w_hyper_exit  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (mc_sync) begin
          if (r_rst_pend) begin
            w_next_state = ST_SERVICE;
            w_next_grant = PRIO_RESET;
            w_take_rst   = 1'b1;
          end else if (hyp && !r_hyper_mode) begin
            w_next_state = ST_HYPER_SERVICE;
            w_next_grant = PRIO_HYP;
          end else if (r_nmi_latch) begin
            w_next_state = ST_SERVICE;
            w_next_grant = PRIO_NMI;
            w_take_nmi   = 1'b1;
          end else if (w_irq_valid) begin
            w_next_state  = ST_SERVICE;
            w_next_grant  = PRIO_IRQ;
            w_next_irq_id = w_irq_idx;
          end
        end
      end
      ST_SERVICE: begin
        if (mc_sync) w_next_state = ST_IDLE;
      end
      ST_HYPER_SERVICE: begin
        if (mc_sync) begin
          w_next_state = ST_IDLE;
          w_hyper_exit = 1'b1;
        end
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_grant      <= PRIO_NONE;
      r_irq_id     <= '0;
      r_rst_pend   <= 1'b1;
      r_nmi_prev   <= 1'b0;
      r_nmi_latch  <= 1'b0;
      r_hyper_mode <= 1'b0;
      r_mask       <= '1;
    end else begin
      // Edge detect runs every clock; a new edge beats a same-cycle clear.
      r_nmi_prev  <= nmi;
      r_nmi_latch <= w_nmi_edge | (r_nmi_latch & ~(ready & w_take_nmi));
      if (ready) begin
        r_grant  <= w_next_grant;
        r_irq_id <= w_next_irq_id;
        if (w_take_rst) r_rst_pend <= 1'b0;
        if (mask_we) r_mask <= mask_wdata;
        if (w_hyper_exit) r_hyper_mode <= 1'b1;
        else if (hyper_rti) r_hyper_mode <= 1'b0;
      end
    end
  end

  assign intg       = (r_state != ST_IDLE);
  assign pc_hold    = intg;
  assign resp       = intg && (r_grant == PRIO_RESET);
  assign nmig       = intg && (r_grant == PRIO_NMI);
  assign hyperg     = intg && (r_grant == PRIO_HYP);
  assign irq_id     = (intg && (r_grant == PRIO_IRQ)) ? r_irq_id : 3'd0;
  assign hyper_mode = r_hyper_mode;
  assign vector_hi  = VEC_PAGE;

  always_comb begin
    vector_lo = VEC_LO_RESET;
    if (intg) begin
      case (r_grant)
        PRIO_NMI: vector_lo = VEC_LO_NMI;
        PRIO_HYP: vector_lo = VEC_LO_HYP;
        PRIO_IRQ: vector_lo = IRQ_VEC_BASE + {4'b0000, r_irq_id, 1'b0};
        default:  vector_lo = VEC_LO_RESET;
      endcase
    end
  end

endmodule

// File: tb/tb_interrupt_arbiter.sv
module tb_interrupt_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic       ready;
  logic [7:0] irq;
  logic       nmi;
  logic       hyp;
  logic       mc_sync;
  logic       i_flag;
  logic       hyper_rti;
  logic       mask_we;
  logic [7:0] mask_wdata;
  logic       intg, nmig, hyperg, resp, pc_hold, hyper_mode;
  logic [2:0] irq_id;
  logic [7:0] vector_hi, vector_lo;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  always #5 clk = ~clk;

  interrupt_arbiter #(
    .NUM_IRQ(8),
    .VEC_PAGE(8'hFF),
    .IRQ_VEC_BASE(8'hE0)
  ) dut (
    .clk(clk), .reset(reset), .ready(ready), .irq(irq), .nmi(nmi),
    .hyp(hyp), .mc_sync(mc_sync), .i_flag(i_flag), .hyper_rti(hyper_rti),
    .mask_we(mask_we), .mask_wdata(mask_wdata),
    .intg(intg), .nmig(nmig), .hyperg(hyperg), .resp(resp),
    .irq_id(irq_id), .pc_hold(pc_hold), .hyper_mode(hyper_mode),
    .vector_hi(vector_hi), .vector_lo(vector_lo)
  );

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] vec();
    return {vector_hi, vector_lo};
  endfunction

  function automatic logic [3:0] flags();
    return {resp, hyperg, nmig, intg};
  endfunction

  initial begin
    reset = 1'b1; ready = 1'b1; irq = '0; nmi = 1'b0; hyp = 1'b0;
    mc_sync = 1'b0; i_flag = 1'b0; hyper_rti = 1'b0;
    mask_we = 1'b0; mask_wdata = '0;
    tick(); tick();
    check("rst_flags", 32'(flags()), 32'h0);
    check("rst_vec", 32'(vec()), 32'hFFFC);
    check("rst_pchold", 32'(pc_hold), 32'h0);
    check("rst_hmode", 32'(hyper_mode), 32'h0);
    check("rst_irqid", 32'(irq_id), 32'h0);

    // Reset sequence wins first sync.
    reset = 1'b0; mc_sync = 1'b1; tick();
    check("resp_flags", 32'(flags()), 32'b1001);
    check("resp_vec", 32'(vec()), 32'hFFFC);
    check("resp_pchold", 32'(pc_hold), 32'h1);
    tick();
    check("resp_exit", 32'(intg), 32'h0);

    // Maskable IRQ, lowest index of 0x0C is 2.
    irq = 8'h0C; tick();
    check("irq2_flags", 32'(flags()), 32'b0001);
    check("irq2_id", 32'(irq_id), 32'h2);
    check("irq2_vec", 32'(vec()), 32'hFFE4);
    ready = 1'b0; tick();
    check("irq2_hold", 32'(intg), 32'h1);
    ready = 1'b1; tick();
    check("irq2_exit", 32'(intg), 32'h0);
    i_flag = 1'b1; tick();
    check("iflag_block", 32'(intg), 32'h0);
    i_flag = 1'b0; irq = '0; mc_sync = 1'b0;

    // NMI pulse while not ready is still latched.
    ready = 1'b0; nmi = 1'b1; tick();
    nmi = 1'b0; tick();
    check("nmi_noready", 32'(intg), 32'h0);
    ready = 1'b1; mc_sync = 1'b1; tick();
    check("nmi_flags", 32'(flags()), 32'b0011);
    check("nmi_vec", 32'(vec()), 32'hFFFA);
    check("nmi_irqid", 32'(irq_id), 32'h0);
    tick(); tick();
    check("nmi_cleared", 32'(intg), 32'h0);
    mc_sync = 1'b0;

    // New NMI edge on the clearing cycle re-arms the latch.
    nmi = 1'b1; tick();
    nmi = 1'b0; tick();
    mc_sync = 1'b1; nmi = 1'b1; tick();
    check("nmi2_flags", 32'(flags()), 32'b0011);
    nmi = 1'b0; tick(); tick();
    check("nmi_setwins", 32'(flags()), 32'b0011);
    tick();
    mc_sync = 1'b0;

    // Hypervisor trap beats irq[0].
    hyp = 1'b1; irq = 8'h01; mc_sync = 1'b1; tick();
    check("hyp_flags", 32'(flags()), 32'b0101);
    check("hyp_vec", 32'(vec()), 32'hFFF8);
    check("hyp_mode_during", 32'(hyper_mode), 32'h0);
    tick();
    check("hyp_exit", 32'(intg), 32'h0);
    check("hyp_mode_set", 32'(hyper_mode), 32'h1);
    tick();
    check("hyp_blocked", 32'(intg), 32'h0);
    mc_sync = 1'b0; hyper_rti = 1'b1; tick();
    hyper_rti = 1'b0;
    check("hyp_rti", 32'(hyper_mode), 32'h0);
    hyp = 1'b0; mc_sync = 1'b1; tick();
    check("irq0_id", 32'(irq_id), 32'h0);
    check("irq0_vec", 32'(vec()), 32'hFFE0);
    tick();
    mc_sync = 1'b0; irq = '0;

    // Mask write on the grant cycle uses the old mask.
    irq = 8'h02; mask_we = 1'b1; mask_wdata = 8'h00; mc_sync = 1'b1; tick();
    mask_we = 1'b0;
    check("mask_old_flags", 32'(flags()), 32'b0001);
    check("mask_old_id", 32'(irq_id), 32'h1);
    check("mask_old_vec", 32'(vec()), 32'hFFE2);
    tick(); tick();
    check("mask_new", 32'(intg), 32'h0);
    mc_sync = 1'b0; mask_we = 1'b1; mask_wdata = 8'hFF; tick();
    mask_we = 1'b0;

    // Reset aborts an active sequence.
    mc_sync = 1'b1; tick();
    check("abort_pre", 32'(intg), 32'h1);
    reset = 1'b1; tick();
    check("abort_intg", 32'(intg), 32'h0);
    check("abort_vec", 32'(vec()), 32'hFFFC);
    reset = 1'b0; tick();
    check("abort_resp", 32'(flags()), 32'b1001);
    check("abort_irqid", 32'(irq_id), 32'h0);
    tick();
    check("abort_exit", 32'(intg), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
